// File: rtl/pad_frame_writer.sv
// Writes a raw IMG_W x IMG_H pixel stream into the line-buffer memory as a
// zero-padded (IMG_W+2) x (IMG_H+2) raster, generating the border internally.
module pad_frame_writer #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic       in_ready,
    output logic       wr,
    output logic [7:0] pixelw,
    output logic [13:0] wcnt,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, TOP, LEFT, DATA, RIGHT, BOT, FIN} state_t;

    localparam logic [8:0] COL_LAST = 9'(IMG_W + 1);
    localparam logic [8:0] COL_DATA = 9'(IMG_W);
    localparam logic [5:0] ROW_BOT  = 6'(IMG_H + 1);

    state_t     state;
    logic [8:0] col;
    logic [5:0] row;

    assign in_ready = (state == DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr     <= 1'b0;
            pixelw <= '0;
            wcnt   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            wr   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= TOP;
                        busy  <= 1'b1;
                        wcnt  <= '0;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                TOP: begin
                    wr     <= 1'b1;
                    pixelw <= '0;
                    wcnt   <= wcnt + 14'd1;
                    if (col == COL_LAST) begin
                        col   <= '0;
                        row   <= 6'd1;
                        state <= LEFT;
                    end else begin
                        col <= col + 9'd1;
                    end
                end
                LEFT: begin
                    wr     <= 1'b1;
                    pixelw <= '0;
                    wcnt   <= wcnt + 14'd1;
                    col    <= 9'd1;
                    state  <= DATA;
                end
                DATA: begin
                    // Without in_valid this is a stall: pixelw and counters hold.
                    if (in_valid) begin
                        wr     <= 1'b1;
                        pixelw <= in_pixel;
                        wcnt   <= wcnt + 14'd1;
                        col    <= col + 9'd1;
                        if (col == COL_DATA)
                            state <= RIGHT;
                    end
                end
                RIGHT: begin
                    wr     <= 1'b1;
                    pixelw <= '0;
                    wcnt   <= wcnt + 14'd1;
                    col    <= '0;
                    row    <= row + 6'd1;
                    state  <= (row + 6'd1 == ROW_BOT) ? BOT : LEFT;
                end
                BOT: begin
                    wr     <= 1'b1;
                    pixelw <= '0;
                    wcnt   <= wcnt + 14'd1;
                    if (col == COL_LAST)
                        state <= FIN;
                    else
                        col <= col + 9'd1;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pad_frame_writer.sv
// Directed bench for pad_frame_writer: full frames, stalls, start-while-busy,
// async reset mid-frame and back-to-back frames against a padded-raster model.
module tb_pad_frame_writer;

    localparam int W     = 256;
    localparam int H     = 32;
    localparam int PW    = W + 2;
    localparam int TOTAL = PW * (H + 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_pixel = 8'h00;
    logic        in_ready;
    logic        wr;
    logic [7:0]  pixelw;
    logic [13:0] wcnt;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    pad_frame_writer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_pixel(in_pixel), .in_ready(in_ready), .wr(wr), .pixelw(pixelw),
        .wcnt(wcnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic bit interior(input int n);
        int r, c;
        r = n / PW;
        c = n % PW;
        return (n < TOTAL) && (r >= 1) && (r <= H) && (c >= 1) && (c <= W);
    endfunction

    // Expected value of padded write n for raw pixel(r,c) = (r+c) mod 256.
    function automatic logic [7:0] exp_write(input int n);
        int r, c;
        r = n / PW;
        c = n % PW;
        if (!interior(n)) return 8'h00;
        return 8'((r - 1) + (c - 1));
    endfunction

    function automatic logic [7:0] raw_pix(input int idx);
        return 8'((idx / W) + (idx % W));
    endfunction

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("idle_wr", 32'(wr), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // Caller is positioned at a negedge; start is raised immediately.
    task automatic run_frame(input int stall_at, input int busy_start_at, input int reset_at);
        int n, raw, dones, stall_left, prev_stall;
        bit stalled, finished;
        n = 0; raw = 0; dones = 0; stall_left = 0; prev_stall = 0;
        stalled = 0; finished = 0;
        start = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_wcnt", 32'(wcnt), 32'd0);
        check("start_done", 32'(done), 32'd0);
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            if (prev_stall != 0)
                check("stall_wr", 32'(wr), 32'd0);
            if (wr) begin
                check("pixelw", 32'(pixelw), 32'(exp_write(n)));
                n++;
                check("wcnt", 32'(wcnt), 32'(n));
            end
            if (done) begin
                dones++;
                check("done_wr", 32'(wr), 32'd0);
                check("done_nwrites", 32'(n), 32'(TOTAL));
                check("done_busy", 32'(busy), 32'd0);
                check("done_wcnt", 32'(wcnt), 32'(TOTAL));
                finished = 1;
            end
            if (!finished) begin
                check("in_ready", 32'(in_ready), 32'(interior(n)));
                if (n == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_wr", 32'(wr), 32'd0);
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_in_ready", 32'(in_ready), 32'd0);
                    check("rst_wcnt", 32'(wcnt), 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    in_valid = 1'b0;
                    return;
                end
                start = (n == busy_start_at && cyc > 0) ? 1'b1 : 1'b0;
                if (n == stall_at && !stalled) begin
                    stall_left = 5;
                    stalled = 1;
                end
                prev_stall = stall_left;
                if (stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                end else begin
                    in_valid = 1'b1;
                end
                in_pixel = in_ready ? raw_pix(raw) : 8'hFF;
                if (in_valid && in_ready) raw++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("frame_done_count", 32'(dones), 32'd1);
        check("frame_raw_consumed", 32'(raw), 32'(W * H));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr", 32'(wr), 32'd0);
        check("reset_pixelw", 32'(pixelw), 32'd0);
        check("reset_wcnt", 32'(wcnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Continuous stream with 0xFF driven during padding.
        run_frame(-1, -1, -1);
        // Back-to-back: start on the cycle after done; stall mid-row 10, start at write 4000.
        run_frame(11 * PW + 101, 4000, -1);
        idle_cycles(3);
        check("hold_wcnt", 32'(wcnt), 32'(TOTAL));
        // Async reset mid-DATA at wcnt=3000, then a clean frame.
        run_frame(-1, -1, 3000);
        idle_cycles(4);
        check("post_rst_wcnt", 32'(wcnt), 32'd0);
        run_frame(-1, -1, -1);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
